crc8_frame_ctrl: RTL and testbench
==================================

CRC8_FRAME_CTRL -- requirements
Module: crc8_frame_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: frame-start pulse, sampled only in IDLE.
REQ-004 SHALL have port len, input, 8 bits: frame length in bytes, 0..255, captured with start.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of the current frame.
REQ-006 SHALL have port s_valid, input, 1 bit: byte-stream valid.
REQ-007 SHALL have port s_data, input, 8 bits: byte-stream data.
REQ-008 SHALL have port s_ready, output, 1 bit: byte accepted on a cycle with s_valid=1 and s_ready=1.
REQ-009 SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when crc_out becomes final.
REQ-011 SHALL have port crc_out, output, 8 bits: frame CRC, held until the next accepted start.

Function
REQ-012 SHALL compute CRC-8 with polynomial 0x07 and init 0x00, feeding each byte MSB-first one bit per cycle; per bit, fb=crc[7]^bit and crc={crc[6:0],1'b0}^(fb?0x07:0x00).
REQ-013 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-014 IDLE: on start=1, SHALL capture len, clear the CRC register to 0x00 and go to LOAD, or go to DONE if len=0.
REQ-015 LOAD: SHALL assert s_ready; on the handshake, SHALL latch s_data, decrement the byte counter and go to SHIFT.
REQ-016 SHIFT: SHALL shift exactly 8 bits over 8 cycles using a 3-bit bit counter, with s_ready=0 throughout.
REQ-017 After the 8th bit, SHALL go to LOAD if the byte counter is nonzero, otherwise to DONE.
REQ-018 DONE: for one cycle, SHALL drive done=1 and load crc_out with the final CRC, then return to IDLE.
REQ-019 With s_valid held high, SHALL complete an N-byte frame with done asserted 9*N+1 cycles after the start edge.
REQ-020 SHALL ignore start while busy=1.
REQ-021 With len=0, SHALL pulse done with crc_out equal to init (after the final XOR, if enabled).
REQ-022 On abort in LOAD or SHIFT, SHALL go to IDLE next cycle with no done pulse and crc_out unchanged.
REQ-023 On abort and start in the same IDLE cycle, start SHALL win and abort SHALL be ignored.
REQ-024 When s_valid=0 in LOAD, SHALL stall indefinitely with the CRC register unchanged.

Reset
REQ-025 On rst=1, SHALL asynchronously set: state=IDLE, s_ready=0, busy=0, done=0, crc_out=0x00, all counters and the CRC register =0.
REQ-026 Reset asserted mid-frame SHALL discard the frame with no done pulse.

Configuration
REQ-027 When macro CRC8_FINAL_XOR_EN is defined, crc_out SHALL be the final register value XOR 0x55 (CRC-8/I-432-1).
REQ-028 When CRC8_FINAL_XOR_EN is undefined, crc_out SHALL be the raw register value; all timing SHALL be identical in both builds.

Structure
REQ-029 A shared package crc8_pkg SHALL hold CRC8_POLY=8'h07, CRC8_INIT=8'h00, CRC8_XOROUT=8'h55 and the FSM state enum.
REQ-030 The bit-serial CRC datapath SHALL be the sub-module crc8_lfsr (clk, rst, clr, en, bit_in, crc); crc8_frame_ctrl SHALL sequence it.

Verification
REQ-031 len=1, byte 0x01 -> done at cycle 10 after start, crc_out=0x07 (0x52 with XOR_EN).
REQ-032 len=1, byte 0x80 -> crc_out=0x89 (0xDC with XOR_EN).
REQ-033 len=9, ASCII "123456789", s_valid always 1 -> done at cycle 82, crc_out=0xF4 (0xA1 with XOR_EN).
REQ-034 len=9, s_valid deasserted 5 cycles before byte 4 -> crc_out=0xF4, done delayed by 5 cycles, s_ready=0 in every SHIFT cycle.
REQ-035 len=0 -> done 1 cycle after start, crc_out=0x00 (0x55 with XOR_EN).
REQ-036 abort during SHIFT of byte 2, and separately rst mid-frame, each with a second start asserted while busy -> no done pulse, prior crc_out retained (0x00 after rst), the start issued while busy ignored, and the next frame correct.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared definitions for the CRC-8 frame controller: polynomial, init and
// output-XOR constants, the controller state enum and a one-bit CRC step.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'h00;
  localparam logic [7:0] CRC8_XOROUT = 8'h55;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Advance the CRC by one message bit, MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// Bit-serial CRC-8 register. clr reloads the init value and takes priority
// over en; en advances the register by one message bit.
module crc8_lfsr
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  // CRC register: clear on frame start, one bit per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/crc8_frame_ctrl.sv
// CRC-8 frame controller: accepts a byte stream of a length given at start,
// feeds each byte MSB-first into crc8_lfsr (8 cycles per byte) and publishes
// the frame CRC on crc_out with a one-cycle done pulse.
// Build option: define CRC8_FINAL_XOR_EN to XOR the final CRC with 0x55;
// timing is identical in both builds.
module crc8_frame_ctrl
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       abort,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] crc_out
);

  state_t     state;
  logic [7:0] byte_cnt;
  logic [7:0] data_reg;
  logic [2:0] bit_cnt;
  logic [7:0] lfsr_crc;
  logic [7:0] crc_final;
  logic       lfsr_clr;
  logic       lfsr_en;
  logic       lfsr_bit;

  // The LFSR is cleared by an accepted start and advances only in SHIFT.
  assign lfsr_clr = (state == IDLE) && start;
  assign lfsr_en  = (state == SHIFT);
  assign lfsr_bit = data_reg[3'd7 - bit_cnt];

`ifdef CRC8_FINAL_XOR_EN
  assign crc_final = lfsr_crc ^ CRC8_XOROUT;
`else
  assign crc_final = lfsr_crc;
`endif

  crc8_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .clr    (lfsr_clr),
    .en     (lfsr_en),
    .bit_in (lfsr_bit),
    .crc    (lfsr_crc)
  );

  // Frame sequencer; s_ready and busy are registered so they track the state
  // exactly (s_ready only in LOAD, busy everywhere except IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_out  <= 8'h00;
      byte_cnt <= 8'h00;
      data_reg <= 8'h00;
      bit_cnt  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort is deliberately not looked at here, so start always wins
          if (start) begin
            byte_cnt <= len;
            bit_cnt  <= 3'd0;
            busy     <= 1'b1;
            if (len == 8'h00) begin
              state <= DONE;
            end else begin
              state   <= LOAD;
              s_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (s_valid) begin
            data_reg <= s_data;
            byte_cnt <= byte_cnt - 8'd1;
            bit_cnt  <= 3'd0;
            s_ready  <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt != 8'h00) begin
                state   <= LOAD;
                s_ready <= 1'b1;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          done    <= 1'b1;
          crc_out <= crc_final;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Bench for crc8_frame_ctrl: fixed vectors, randomized frames with random
// s_valid gaps, start-while-busy, abort and mid-frame reset, all checked
// against a byte-wise CRC-8 reference and cycle-count expectations.
module tb_crc8_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       busy;
  logic       done;
  logic [7:0] crc_out;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] frame_bytes [256];
  logic [7:0] exp_last = 8'h00;

  crc8_frame_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .abort   (abort),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .busy    (busy),
    .done    (done),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte-at-a-time CRC-8 (poly 0x07, init 0x00) over frame_bytes[0..n-1].
  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ frame_bytes[i];
      for (int k = 0; k < 8; k++) begin
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
    end
`ifdef CRC8_FINAL_XOR_EN
    c = c ^ 8'h55;
`endif
    return c;
  endfunction

  // One frame: done must come 1 + 9*n + (LOAD cycles spent without s_valid)
  // cycles after the start edge, and s_ready must stay low for the 8 cycles
  // following each accepted byte.
  task automatic run_frame(input int n, input int stall_idx, input int stall_n,
                           input bit rnd_stall, input bit busy_start,
                           input bit abort_with_start, input string tag);
    int cyc, idx, stalls, stall_used, shift_left, viol, hs, done_cyc;
    logic [7:0] exp_crc;
    cyc = 0; idx = 0; stalls = 0; stall_used = 0; shift_left = 0;
    viol = 0; hs = 0; done_cyc = -1;
    exp_crc = ref_crc(n);
    @(negedge clk);
    start = 1'b1; len = n[7:0]; abort = abort_with_start; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    while (cyc < 4000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (shift_left > 0) begin
        if (s_ready) viol++;
        shift_left--;
      end
      start = busy_start && (cyc == 3);
      if (start) len = 8'd1;
      if (s_ready) begin
        if (idx == stall_idx && stall_used < stall_n) begin
          s_valid = 1'b0; stall_used++; stalls++;
        end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
          s_valid = 1'b0; stalls++;
        end else begin
          s_valid = 1'b1; s_data = frame_bytes[idx];
        end
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom);
      end
      if (s_ready && s_valid) begin
        hs++; idx++; shift_left = 8;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; s_valid = 1'b0;
    check_val({tag, "_done_cyc"}, done_cyc, 1 + 9 * n + stalls);
    check_val({tag, "_crc"}, {24'h0, crc_out}, {24'h0, exp_crc});
    check_val({tag, "_handshakes"}, hs, n);
    check_val({tag, "_sready_shift"}, viol, 0);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    check_val({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    $display("frame %s len=%0d stalls=%0d done_cyc=%0d crc=%02h exp=%02h",
             tag, n, stalls, done_cyc, crc_out, exp_crc);
    exp_last = exp_crc;
  endtask

  // Four-byte frame killed during SHIFT of byte 2 by abort or by reset, with a
  // start pulsed while busy; no done may appear and crc_out must hold.
  task automatic run_kill(input bit use_rst, input string tag);
    int idx, dones, busy_late;
    idx = 0; dones = 0; busy_late = 0;
    for (int i = 0; i < 4; i++) frame_bytes[i] = 8'($urandom);
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) dones++;
      if (cyc > 14 && busy) busy_late++;
      start = (cyc == 5);
      len   = (cyc == 5) ? 8'd1 : 8'd4;
      if (use_rst) rst = (cyc == 13);
      else         abort = (cyc == 13);
      s_valid = (idx < 4);
      s_data  = frame_bytes[idx[7:0]];
      if (s_ready && s_valid) idx++;
      @(negedge clk);
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; s_valid = 1'b0;
    if (use_rst) exp_last = 8'h00;
    check_val({tag, "_no_done"}, dones, 0);
    check_val({tag, "_idle"}, busy_late, 0);
    check_val({tag, "_crc_held"}, {24'h0, crc_out}, {24'h0, exp_last});
    $display("kill %s bytes_taken=%0d dones=%0d crc=%02h exp=%02h",
             tag, idx, dones, crc_out, exp_last);
  endtask

  initial begin
    string      s;
    logic [7:0] k01, k80, k9, k0;
`ifdef CRC8_FINAL_XOR_EN
    k01 = 8'h52; k80 = 8'hDC; k9 = 8'hA1; k0 = 8'h55;
`else
    k01 = 8'h07; k80 = 8'h89; k9 = 8'hF4; k0 = 8'h00;
`endif
    rst = 1'b1; start = 1'b0; len = 8'h00; abort = 1'b0;
    s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_sready", {31'h0, s_ready}, 32'h0);
    check_val("rst_busy",   {31'h0, busy},    32'h0);
    check_val("rst_done",   {31'h0, done},    32'h0);
    check_val("rst_crc",    {24'h0, crc_out}, 32'h0);
    rst = 1'b0;
    $display("reset released");

    frame_bytes[0] = 8'h01;
    run_frame(1, -1, 0, 1'b0, 1'b0, 1'b0, "b01");
    check_val("b01_const", {24'h0, crc_out}, {24'h0, k01});

    frame_bytes[0] = 8'h80;
    run_frame(1, -1, 0, 1'b0, 1'b0, 1'b1, "b80_abort_start");
    check_val("b80_const", {24'h0, crc_out}, {24'h0, k80});

    s = "123456789";
    for (int i = 0; i < 9; i++) frame_bytes[i] = s[i];
    run_frame(9, -1, 0, 1'b0, 1'b0, 1'b0, "ascii9");
    check_val("ascii9_const", {24'h0, crc_out}, {24'h0, k9});

    run_frame(9, 3, 5, 1'b0, 1'b0, 1'b0, "ascii9_stall5");
    check_val("ascii9_stall_const", {24'h0, crc_out}, {24'h0, k9});

    run_frame(0, -1, 0, 1'b0, 1'b0, 1'b0, "len0");
    check_val("len0_const", {24'h0, crc_out}, {24'h0, k0});

    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) frame_bytes[i] = 8'($urandom);
      run_frame(n, -1, 0, 1'b1, (f % 2) == 0, 1'b0, $sformatf("rnd%0d", f));
    end

    run_kill(1'b0, "abort");
    frame_bytes[0] = 8'h80; frame_bytes[1] = 8'h3C;
    run_frame(2, -1, 0, 1'b0, 1'b0, 1'b0, "after_abort");

    run_kill(1'b1, "reset");
    frame_bytes[0] = 8'h01;
    run_frame(1, -1, 0, 1'b1, 1'b1, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
